// File: rtl/cmip_fifo_wd_conv_nrw.sv
// Wide-to-narrow FWFT FIFO: stores wide words, then unpacks each into RATE narrow slices.
// Define CMIP_WD_CONV_LSB_FIRST_EN to emit the LSB slice first (default is MSB slice first).
module cmip_fifo_wd_conv_nrw #(
  parameter  int DPTH       = 32,
  parameter  int WR_DATA_WD = 512,
  parameter  int RD_DATA_WD = 128,
  parameter  int ADDR_WD    = $clog2(DPTH),
  localparam int RATE       = WR_DATA_WD / RD_DATA_WD,
  localparam int RATE_BITS  = $clog2(RATE),
  localparam int CNT_WD     = ADDR_WD + RATE_BITS + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [WR_DATA_WD-1:0] i_din,
  output logic                  o_full,
  output logic                  o_ovfl,
  output logic [ADDR_WD:0]      o_wr_cnt,
  input  logic                  i_rd,
  output logic [RD_DATA_WD-1:0] o_dout,
  output logic                  o_empty,
  output logic [CNT_WD-1:0]     o_rd_cnt
);

  logic [WR_DATA_WD-1:0] r_mem [DPTH];
  logic [ADDR_WD:0]      r_wr_ptr;
  logic [ADDR_WD:0]      r_rd_ptr;
  logic [WR_DATA_WD-1:0] r_hold;
  logic                  r_hold_vld;
  logic [RATE_BITS-1:0]  r_sub_cnt;
  logic                  r_ovfl;

  logic [ADDR_WD:0]      w_cnt;
  logic                  w_full;
  logic                  w_store_nempty;
  logic                  w_last_rd;
  logic                  w_load;
  logic                  w_wr_acc;
  logic [RD_DATA_WD-1:0] w_slice [RATE];

  assign w_cnt          = r_wr_ptr - r_rd_ptr;
  assign w_full         = (r_wr_ptr[ADDR_WD] != r_rd_ptr[ADDR_WD]) &&
                          (r_wr_ptr[ADDR_WD-1:0] == r_rd_ptr[ADDR_WD-1:0]);
  assign w_store_nempty = (r_wr_ptr != r_rd_ptr);
  assign w_last_rd      = i_rd & r_hold_vld & (r_sub_cnt == RATE_BITS'(RATE - 1));
  // Reload on the last slice keeps back-to-back wide words bubble-free.
  assign w_load         = (~r_hold_vld | w_last_rd) & w_store_nempty;
  assign w_wr_acc       = i_wr & ~w_full;

  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[ADDR_WD-1:0]] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_sub_cnt  <= '0;
      r_ovfl     <= 1'b0;
    end else begin
      r_ovfl <= i_wr & w_full;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load) begin
        r_hold     <= r_mem[r_rd_ptr[ADDR_WD-1:0]];
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_hold_vld <= 1'b1;
        r_sub_cnt  <= '0;
      end else if (w_last_rd) begin
        // sub_cnt is left alone so o_dout keeps showing the last slice
        r_hold_vld <= 1'b0;
      end else if (i_rd & r_hold_vld) begin
        r_sub_cnt <= r_sub_cnt + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RATE; gi++) begin : g_slice
`ifdef CMIP_WD_CONV_LSB_FIRST_EN
      assign w_slice[gi] = r_hold[gi*RD_DATA_WD +: RD_DATA_WD];
`else
      assign w_slice[gi] = r_hold[(RATE-1-gi)*RD_DATA_WD +: RD_DATA_WD];
`endif
    end
  endgenerate

  assign o_dout   = w_slice[r_sub_cnt];
  assign o_empty  = ~r_hold_vld;
  assign o_full   = w_full;
  assign o_ovfl   = r_ovfl;
  assign o_wr_cnt = w_cnt;
  assign o_rd_cnt = {w_cnt, {RATE_BITS{1'b0}}} +
                    (r_hold_vld ? (CNT_WD'(RATE) - CNT_WD'(r_sub_cnt)) : CNT_WD'(0));

endmodule

// File: tb/tb_cmip_fifo_wd_conv_nrw.sv
// Scoreboard bench for cmip_fifo_wd_conv_nrw: a count-level model predicts flags/counts,
// a queue of narrow words predicts the data order (honours CMIP_WD_CONV_LSB_FIRST_EN).
module tb_cmip_fifo_wd_conv_nrw;

  localparam int DPTH   = 32;
  localparam int WR_WD  = 512;
  localparam int RD_WD  = 128;
  localparam int AW     = 5;
  localparam int RATE   = 4;
  localparam int CNT_WD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr  = 1'b0;
  logic              rd  = 1'b0;
  logic [WR_WD-1:0]  din = '0;
  logic              o_full, o_ovfl, o_empty;
  logic [AW:0]       o_wr_cnt;
  logic [RD_WD-1:0]  o_dout;
  logic [CNT_WD-1:0] o_rd_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state: wide words in storage, narrow words left in the unpack stage.
  int               n_store = 0;
  int               n_hold  = 0;
  bit               exp_ovfl = 1'b0;
  bit               mdl_vld  = 1'b0;
  logic [RD_WD-1:0] exp_q[$];

  cmip_fifo_wd_conv_nrw #(.DPTH(DPTH), .WR_DATA_WD(WR_WD), .RD_DATA_WD(RD_WD)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_wr    (wr),
    .i_din   (din),
    .o_full  (o_full),
    .o_ovfl  (o_ovfl),
    .o_wr_cnt(o_wr_cnt),
    .i_rd    (rd),
    .o_dout  (o_dout),
    .o_empty (o_empty),
    .o_rd_cnt(o_rd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RD_WD-1:0] act, input logic [RD_WD-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WR_WD-1:0] rnd_word();
    logic [WR_WD-1:0] w;
    for (int i = 0; i < WR_WD / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drive(input bit w, input logic [WR_WD-1:0] d, input bit r, input bit rs);
    wr  = w;
    din = d;
    rd  = r;
    rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (n_store > 0 || n_hold > 0); i++) drive(0, '0, 1, 0);
    drive(0, '0, 0, 0);
  endtask

  // Monitor: checks the state produced by the last edge, then advances the model
  // with the inputs that the next edge will sample.
  always @(negedge clk) begin
    bit last, cons, load, acc;
    if (mdl_vld) begin
      chk("empty",  o_empty,  (n_hold == 0));
      chk("full",   o_full,   (n_store == DPTH));
      chk("ovfl",   o_ovfl,   exp_ovfl);
      chk("wr_cnt", o_wr_cnt, n_store);
      chk("rd_cnt", o_rd_cnt, n_store * RATE + n_hold);
      if (!rst && rd && n_hold > 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", o_dout, 'x);
        end else begin
          chk("dout", o_dout, exp_q.pop_front());
        end
      end
    end
    if (rst) begin
      n_store  = 0;
      n_hold   = 0;
      exp_ovfl = 1'b0;
      exp_q.delete();
      mdl_vld  = 1'b1;
    end else if (mdl_vld) begin
      cons     = rd && n_hold > 0;
      last     = rd && n_hold == 1;
      load     = (n_hold == 0 || last) && n_store > 0;
      acc      = wr && n_store < DPTH;
      exp_ovfl = wr && n_store == DPTH;
      if (acc) begin
        for (int k = 0; k < RATE; k++) begin
`ifdef CMIP_WD_CONV_LSB_FIRST_EN
          exp_q.push_back(din[k*RD_WD +: RD_WD]);
`else
          exp_q.push_back(din[(RATE-1-k)*RD_WD +: RD_WD]);
`endif
        end
      end
      n_hold  = load ? RATE : (cons ? n_hold - 1 : n_hold);
      n_store = n_store + int'(acc) - int'(load);
    end
  end

  initial begin
    int wp, rp;
    // T1: reset held 3 cycles with writes requested
    for (int i = 0; i < 3; i++) drive(1, rnd_word(), 0, 1);
    drive(0, '0, 0, 0);
    chk("rst_dout", o_dout, '0);

    // T2: single word, continuous read
    drive(1, rnd_word(), 1, 0);
    for (int i = 0; i < 6; i++) drive(0, '0, 1, 0);

    // T3: 8 back-to-back words while reading
    for (int i = 0; i < 8; i++) drive(1, rnd_word(), 1, 0);
    drain();

    // T4: 33 writes without reading, then read everything
    for (int i = 0; i < 33; i++) drive(1, rnd_word(), 0, 0);
    drive(0, '0, 0, 0);
    drain();

    // T5: reads while empty, then write coinciding with the last slice read
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
    drive(1, rnd_word(), 0, 0);
    drive(0, '0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, '0, 1, 0);
    drive(1, rnd_word(), 1, 0);
    drain();

    // T6: reset after 2 of 4 slices, then a fresh word
    drive(1, rnd_word(), 0, 0);
    drive(0, '0, 0, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 0, 1);
    drive(1, rnd_word(), 0, 0);
    drain();

    // Random traffic in phases biased towards filling or emptying
    for (int i = 0; i < 3000; i++) begin
      wp = ((i / 300) % 2 == 0) ? 80 : 30;
      rp = ((i / 300) % 2 == 0) ? 40 : 90;
      drive($urandom_range(99) < wp, rnd_word(), $urandom_range(99) < rp,
            $urandom_range(999) == 0);
    end
    drain();
    chk("sb_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
